uart_tx_fifo: RTL and testbench

//   8N1 UART transmitter with a small input FIFO. It sits directly downstream of the
//   io_ctl byte source: it takes io_ctl's dout/tx_en, returns tx_rdy, and drives the

---
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames are sent LSB first and
// back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       tx_en,
    output logic       tx_rdy,
    output logic       tx,
    output logic       busy,
    output logic       ovf
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic full, empty, push, pop, bit_end;

    always_comb begin
        full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        empty   = (count_q == '0);
        push    = tx_en & ~full;
        bit_end = (cnt_q == CNT_W'(DIV - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    // Next-state logic; a pop happens on leaving IDLE or at the end of STOP
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && idx_q == 3'd7) state_d = STOP;
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;

        shift_d = shift_q;
        if (pop) shift_d = mem_q[rd_ptr_q];
        else if (state_q == DATA && bit_end) shift_d = {1'b0, shift_q[7:1]};

        idx_d = idx_q;
        if (state_q == START) idx_d = '0;
        else if (state_q == DATA && bit_end) idx_d = idx_q + 1'b1;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Outputs; tx is registered from the next state so it never glitches
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        tx     = tx_q;
        tx_rdy = ~full;
        busy   = (state_q != IDLE) | ~empty;
        ovf    = tx_en & full;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writers push expected bytes, a UART line
// monitor decodes tx and pops/compares each received frame.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int unsigned DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       tx_en = 1'b0;
    logic       tx_rdy, tx, busy, ovf;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .tx_en(tx_en),
        .tx_rdy(tx_rdy), .tx(tx), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ovf_seen = 0;
    logic [7:0]  exp_q[$];
    int          starts[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ovf) ovf_seen <= ovf_seen + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller is positioned just after a posedge; the write is captured at the next one.
    task automatic put(input logic [7:0] b, input bit accept);
        din   = b;
        tx_en = 1'b1;
        @(negedge clk);
        chk("tx_rdy_at_write", tx_rdy, accept);
        chk("ovf_at_write", ovf, !accept);
        if (accept) exp_q.push_back(b);
        @(posedge clk);
        #1;
        tx_en = 1'b0;
        din   = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk({name, "_idle_timeout"}, done, 1);
        idle(3);
        chk({name, "_all_bytes_seen"}, exp_q.size(), 0);
    endtask

    task automatic chk_gaps(input string name, input int first, input int n);
        chk({name, "_frame_count"}, starts.size() - first, n);
        for (int i = first; i + 1 < starts.size(); i++)
            chk({name, "_back_to_back"}, starts[i+1] - starts[i], 10 * DIV);
    endtask

    // Line monitor: samples on negedges, abandons a frame if reset is asserted.
    initial begin : monitor
        logic [9:0] bits;
        bit         glitch, aborted;
        int         fstart;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                fstart  = cyc;
                glitch  = 0;
                aborted = 0;
                bits    = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int k = 0; k < DIV && !aborted; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (!rst_n) aborted = 1;
                        else if (k == 0) bits[b] = tx;
                        else if (tx !== bits[b]) glitch = 1;
                    end
                end
                if (!aborted) begin
                    starts.push_back(fstart);
                    chk("start_bit", bits[0], 0);
                    chk("stop_bit", bits[9], 1);
                    chk("bit_width_stable", glitch, 0);
                    if (exp_q.size() == 0) chk("unexpected_frame", bits[8:1], 32'hFFFF_FFFF);
                    else chk("frame_byte", bits[8:1], exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int    si, n, lows, ovf0;
        string s;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_rdy", tx_rdy, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", ovf, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // 1: single 0x55 -- latency and busy window
        si = starts.size();
        put(8'h55, 1);
        @(negedge clk);
        chk("t1_busy_after_write", busy, 1);
        chk("t1_tx_high_before_pop", tx, 1);
        @(negedge clk);
        chk("t1_tx_low_after_pop", tx, 0);
        n = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("t1_busy_cycles_from_start", n, 100);
        idle(1);
        wait_idle("t1");
        chk_gaps("t1", si, 1);

        // 2: six consecutive writes, sixth overflows
        si = starts.size();
        ovf0 = ovf_seen;
        for (int i = 0; i < 5; i++) put(8'(i), 1);
        put(8'h05, 0);
        wait_idle("t2");
        chk("t2_ovf_pulses", ovf_seen - ovf0, 1);
        chk_gaps("t2", si, 5);

        // 3: flow-controlled string
        s = "Hello, world!\r\n";
        ovf0 = ovf_seen;
        si = starts.size();
        for (int i = 0; i < s.len(); i++) begin
            for (int w = 0; w < 2000 && !tx_rdy; w++) idle(1);
            put(s[i], 1);
        end
        wait_idle("t3");
        chk("t3_no_ovf", ovf_seen - ovf0, 0);
        chk_gaps("t3", si, 15);

        // 4: all-ones then all-zeros frame
        si = starts.size();
        put(8'hFF, 1);
        put(8'h00, 1);
        wait_idle("t4");
        chk_gaps("t4", si, 2);

        // 5: write coincides with STOP->START pop while full (edge N+101)
        si = starts.size();
        for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i), 1);
        idle(96);
        put(8'h5A, 0);
        put(8'hC3, 1);
        wait_idle("t5");
        chk_gaps("t5", si, 6);

        // 6: reset during DATA bit 3 with two bytes queued
        si = starts.size();
        put(8'hA5, 1);
        put(8'h3C, 1);
        put(8'h81, 1);
        idle(42);
        chk("t6_tx_bit3_before_reset", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_tx_on_reset", tx, 1);
        chk("t6_busy_on_reset", busy, 0);
        chk("t6_tx_rdy_on_reset", tx_rdy, 1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("t6_line_quiet_after_reset", lows, 0);
        chk("t6_no_new_frames", starts.size() - si, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
